// File: rtl/srl_pipe.sv
// srl_pipe: 4-stage pipelined 16-bit right shifter (8,4,2,1), logical/arithmetic, valid/ready.
// Define SRL_PIPE_ROUND_EN to round half up using the guard bit; otherwise the result is truncated.
module srl_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [3:0]  shift,
  input  logic        arith,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out
);
`ifdef SRL_PIPE_ROUND_EN
  localparam int W = 17;
`else
  localparam int W = 16;
`endif
  logic         en;
  logic [W-1:0] x0, y;
  logic         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic [W-1:0] x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
  logic [2:0]   sh1_q, sh1_d;
  logic [1:0]   sh2_q, sh2_d;
  logic         sh3_q, sh3_d;
  logic         f1_q, f1_d, f2_q, f2_d, f3_q, f3_d;
  logic [15:0]  out_q, out_d;
  // {value, guard} shifted right by n with the carried fill bit when s is set
  function automatic logic [W-1:0] rsh(input logic [W-1:0] x, input logic f, input logic s, input int n);
    logic [W-1:0] t;
    t = W'({{16{f}}, x} >> n);
    return s ? t : x;
  endfunction
  assign en        = !v4_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v4_q;
  assign out       = out_q;
  always_comb begin
`ifdef SRL_PIPE_ROUND_EN
    x0 = {a, 1'b0};
`else
    x0 = a;
`endif
    f1_d  = arith & a[15];
    v1_d  = in_valid;
    x1_d  = rsh(x0, f1_d, shift[3], 8);
    sh1_d = shift[2:0];
    v2_d  = v1_q;
    x2_d  = rsh(x1_q, f1_q, sh1_q[2], 4);
    sh2_d = sh1_q[1:0];
    f2_d  = f1_q;
    v3_d  = v2_q;
    x3_d  = rsh(x2_q, f2_q, sh2_q[1], 2);
    sh3_d = sh2_q[0];
    f3_d  = f2_q;
    v4_d  = v3_q;
    y     = rsh(x3_q, f3_q, sh3_q, 1);
`ifdef SRL_PIPE_ROUND_EN
    out_d = y[16:1] + 16'(y[0]);
`else
    out_d = y;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      v4_q  <= 1'b0;
      x1_q  <= '0;
      x2_q  <= '0;
      x3_q  <= '0;
      sh1_q <= '0;
      sh2_q <= '0;
      sh3_q <= 1'b0;
      f1_q  <= 1'b0;
      f2_q  <= 1'b0;
      f3_q  <= 1'b0;
      out_q <= '0;
    end else if (en) begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      v4_q  <= v4_d;
      x1_q  <= x1_d;
      x2_q  <= x2_d;
      x3_q  <= x3_d;
      sh1_q <= sh1_d;
      sh2_q <= sh2_d;
      sh3_q <= sh3_d;
      f1_q  <= f1_d;
      f2_q  <= f2_d;
      f3_q  <= f3_d;
      out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_srl_pipe.sv
// tb_srl_pipe: scoreboard bench for srl_pipe; honours SRL_PIPE_ROUND_EN for expected values.
module tb_srl_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [3:0]  shift = '0;
  logic        arith = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out;
  typedef struct {
    logic [15:0] v;
    int          c;
  } ent_t;
  ent_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic lat_chk = 1'b0;
  logic f;
  int   sent;
  srl_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .shift(shift),
    .arith(arith), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [15:0] model(input logic [15:0] x, input logic [3:0] s, input logic ar);
    logic [15:0] r;
    r = ar ? 16'($signed(x) >>> s) : x >> s;
`ifdef SRL_PIPE_ROUND_EN
    if (s != 0) r = r + 16'(x[s - 4'd1]);
`endif
    return r;
  endfunction
  task automatic step(input logic iv, input logic [15:0] ia, input logic [3:0] ish, input logic iar,
                      input logic ordy, input logic xen, input logic [15:0] xv, output logic fired);
    ent_t e;
    @(negedge clk);
    in_valid = iv; a = ia; shift = ish; arith = iar; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !(out_valid && !out_ready));
    if (out_valid && out_ready) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out", out, e.v);
        if (lat_chk) chk("latency", cyc - e.c, 4);
      end
    end
    fired = iv && in_ready;
    if (fired) sb.push_back(ent_t'{xen ? xv : model(ia, ish, iar), cyc});
    cyc++;
  endtask
  task automatic idle(input int n);
    logic d;
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0, d);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_in_ready", in_ready, 1);
    lat_chk = 1'b1;
    step(1, 16'hF0F0, 4'd4, 0, 1, 1, 16'h0F0F, f);
    step(1, 16'h8000, 4'd15, 1, 1, 1, 16'hFFFF, f);
    step(1, 16'h8000, 4'd3, 1, 1, 1, 16'hF000, f);
    step(1, 16'h8000, 4'd3, 0, 1, 1, 16'h1000, f);
`ifdef SRL_PIPE_ROUND_EN
    step(1, 16'h0018, 4'd4, 0, 1, 1, 16'h0002, f);
    step(1, 16'hFFFF, 4'd1, 1, 1, 1, 16'h0000, f);
`else
    step(1, 16'h0018, 4'd4, 0, 1, 1, 16'h0001, f);
    step(1, 16'hFFFF, 4'd1, 1, 1, 1, 16'hFFFF, f);
`endif
    step(1, 16'h1234, 4'd0, 0, 1, 1, 16'h1234, f);
    step(1, 16'hFFFF, 4'd15, 0, 1, 0, 16'h0, f);
    idle(6);
    chk("directed_drain", sb.size(), 0);
    lat_chk = 1'b0;
    sent = 0;
    for (int i = 0; i < 40 && (sent < 8 || sb.size() != 0); i++) begin
      step(sent < 8, 16'(sent), 4'd1, 0, !(i >= 4 && i < 7), 0, 16'h0, f);
      if (f) sent++;
    end
    chk("bp_sent", sent, 8);
    chk("bp_drain", sb.size(), 0);
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 16'h0100 + 16'(i), 4'd2, 0, 1, 0, 16'h0, f);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out", out, 0);
    chk("flush_in_ready", in_ready, 1);
    sb.delete();
    cyc++;
    step(1, 16'h4321, 4'd4, 0, 1, 1, 16'h0432, f);
    idle(6);
    chk("flush_drain", sb.size(), 0);
    lat_chk = 1'b0;
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, 0, 16'h0, f);
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    chk("final_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
